audio_pcm_fifo_wb: RTL
======================

# audio_pcm_fifo_wb

Wishbone-classic responder that receives stereo PCM samples from the CPU data bus and plays them out at a fixed sample rate. It holds stereo sample pairs in a FIFO and uses a tick pacer to pop one pair every `TICKS_PER_SAMPLE` clocks. Each pair is presented on a strobed parallel PCM port for the DAC/serializer. It sits behind the `0x1000_00xx` decode on the LSU Wishbone bus. It replaces the behavioural water-level model with real buffering, backpressure and underrun accounting.

## Interface
- `DEPTH`, 64: FIFO depth in stereo pairs; power of two, ≥4.
- `TICKS_PER_SAMPLE`, 680: clocks per output sample (30 MHz / 44.1 kHz).
- `START_LEVEL`, 40: fill level (pairs) that must be exceeded to leave PREFILL; must be < `DEPTH`.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset: asynchronous assert, active-low.
- `wb_cyc`  in  1  Wishbone cycle; already qualified by the external `0x1000_00xx` decode.
- `wb_stb`  in  1  Wishbone strobe.
- `wb_we`  in  1  write enable.
- `wb_adr`  in  4  word address bits [3:0]; byte offset = `wb_adr`·4.
- `wb_dat_i`  in  32  write data.
- `wb_sel`  in  4  byte selects; ignored, all accesses are treated as 32-bit.
- `wb_dat_o`  out  32  read data.
- `wb_ack`  out  1  acknowledge.
- `pcm_valid`  out  1  one-cycle strobe, once per output sample period while PLAY.
- `pcm_left`, `pcm_right`  out  16 each  signed samples; held between strobes.
- `underrun`  out  1  one-cycle pulse when a scheduled pop finds the FIFO empty.

## Operation
- Register map (byte offsets):
  - 0x10 LEFT (W): stages `wb_dat_i[15:0]`.
  - 0x20 RIGHT (W): pushes the pair {staged left, `wb_dat_i[15:0]`}.
  - 0x24 STATUS (R): [15:0] fill, [16] full, [17] empty, [18] playing, others 0.
  - 0x28 UNDERRUNS (R): 16-bit underrun counter; any write to 0x28 clears it.
  - 0x2C CTRL (W): bit0 = flush.
- Unmapped offsets: writes are acked and ignored; reads are acked and return 0.
- LEFT write: updates the staging register and acks; the FIFO is unchanged.
- RIGHT write when not full: pushes the pair; the staging register keeps its value.
- RIGHT write when full: `wb_ack` is held low (wait states) until a pop frees a slot, then the push completes with ack.
- Pacer FSM, PREFILL/PLAY:
  - PREFILL: tick counter held at 0, no pops, `pcm_valid` stays 0. Move to PLAY when fill > `START_LEVEL`.
  - PLAY: the tick counter counts 0..`TICKS_PER_SAMPLE`−1. At terminal count, one sample slot fires:
    - FIFO non-empty: pop, drive the pair on `pcm_left`/`pcm_right`, pulse `pcm_valid`.
    - FIFO empty: drive zeros, pulse `pcm_valid` and `underrun`, increment UNDERRUNS (saturating at 0xFFFF), go to PREFILL.
- Flush (CTRL bit0 = 1):
  - empties the FIFO, zeroes the staging register and tick counter, forces PREFILL;
  - does not touch UNDERRUNS or the PCM outputs;
  - a stalled RIGHT write cannot coexist with it, since only one bus access is in flight.
- Arithmetic:
  - fill is log2(`DEPTH`)+1 bits; read/write pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
  - Full is fill==`DEPTH`; empty is fill==0.
  - Simultaneous push and pop: fill is unchanged and both pointers advance.
- Reset values:
  - Outputs: `wb_ack`, `wb_dat_o`, `pcm_valid`, `pcm_left`, `pcm_right`, `underrun` = 0.
  - Internal state: FIFO empty, pointers 0, staging 0, UNDERRUNS 0, state PREFILL, tick counter 0.
- Reset assertion mid-transfer abandons the bus cycle; no ack is issued for it.

## Timing
- Writes (no stall): `wb_ack` is combinational in the same cycle `wb_cyc && wb_stb` is seen; the register/FIFO update lands on that clock edge.
- Reads: ack comes in the second cycle of the strobe, matching the memory slaves:
  - ack = `stb && cyc && stb_q && cyc_q && !ack_q`;
  - `wb_dat_o` is registered in the first cycle and sampled at the first cycle's edge.
- Full stall:
  - "full" is evaluated from the registered fill;
  - a pop at edge N makes the RIGHT write ack in cycle N+1; a push is never accepted in the same cycle as the pop that frees space.
- Pop to output: `pcm_*` and `pcm_valid` are registered and appear in the cycle after the terminal tick.
- In steady PLAY, `pcm_valid` strobes are exactly `TICKS_PER_SAMPLE` cycles apart.
- PREFILL→PLAY: registered. The first `pcm_valid` comes `TICKS_PER_SAMPLE` cycles after entering PLAY.
- Register reads reflect state as of the first strobe cycle.

## Test plan
- **Prefill and start:** reset; write 41 pairs (L=n, R=−n).
  - PLAY after the 41st RIGHT ack;
  - first `pcm_valid` 680 cycles later with left=1, right=0xFFFF;
  - subsequent strobes 680 cycles apart.
- **Backpressure:** `DEPTH`=64, fill to 64 while in PLAY; 65th RIGHT write stalls until the next pop, then acks one cycle after `pcm_valid`'s pop edge; fill reads 64.
- **Underrun:** prefill 41 pairs and stop writing.
  - 41 valid samples, then the 42nd strobe carries zeros with `underrun`=1;
  - UNDERRUNS=1, STATUS[18]=0;
  - writing 0x28 clears the count to 0.
- **Read latency/status:** empty FIFO, read 0x24 → ack on the 2nd strobe cycle, data 0x0002_0000; after 3 pushes, data 0x0000_0003.
- **Flush:** in PLAY with fill 20, write 0x2C=1.
  - STATUS = 0x0002_0000 next read;
  - no `pcm_valid` until >40 pairs are rewritten;
  - UNDERRUNS unchanged.
- **Async reset mid-play:** drop `resetn` asynchronously between edges while `pcm_valid` pending → outputs 0 immediately, fill 0, PREFILL after release.

Source files
------------

// File: rtl/audio_pcm_fifo_wb.sv
// Wishbone-classic PCM sink: CPU writes stereo pairs into a FIFO, a tick pacer
// pops one pair per sample period onto a strobed parallel PCM port.
module audio_pcm_fifo_wb #(
   parameter int DEPTH            = 64,
   parameter int TICKS_PER_SAMPLE = 680,
   parameter int START_LEVEL      = 40
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [3:0]  wb_adr,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack,
   output logic        pcm_valid,
   output logic [15:0] pcm_left,
   output logic [15:0] pcm_right,
   output logic        underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int TW = (TICKS_PER_SAMPLE > 1) ? $clog2(TICKS_PER_SAMPLE) : 1;
   localparam logic [FW-1:0] FILL_FULL  = FW'(DEPTH);
   localparam logic [FW-1:0] FILL_START = FW'(START_LEVEL);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SAMPLE - 1);

   // Word addresses (byte offset / 4)
   localparam logic [3:0] ADR_LEFT   = 4'h4;
   localparam logic [3:0] ADR_RIGHT  = 4'h8;
   localparam logic [3:0] ADR_STATUS = 4'h9;
   localparam logic [3:0] ADR_UNDER  = 4'hA;
   localparam logic [3:0] ADR_CTRL   = 4'hB;

   typedef enum logic {ST_PREFILL, ST_PLAY} state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]  fill_q, fill_d;
   logic [15:0]    stage_q, stage_d;
   logic [15:0]    under_cnt_q, under_cnt_d;
   logic           req_q, req_d;
   logic           ack_q, ack_d;
   logic [31:0]    dat_q, dat_d;
   logic           pcm_valid_q, pcm_valid_d;
   logic [15:0]    pcm_left_q, pcm_left_d;
   logic [15:0]    pcm_right_q, pcm_right_d;
   logic           underrun_q, underrun_d;

   logic [31:0]    mem [DEPTH];
   logic [31:0]    head_word;
   logic [31:0]    rd_data;

   logic req, wr, rd, full, empty, stall, push, flush, slot, pop;
   logic unused_bits;

   assign unused_bits = ^{wb_sel, wb_dat_i[31:16]};

   assign req   = wb_cyc && wb_stb;
   assign wr    = req && wb_we;
   assign rd    = req && !wb_we;
   assign full  = (fill_q == FILL_FULL);
   assign empty = (fill_q == '0);
   assign stall = wr && (wb_adr == ADR_RIGHT) && full;
   assign push  = wr && (wb_adr == ADR_RIGHT) && !full;
   assign flush = wr && (wb_adr == ADR_CTRL) && wb_dat_i[0];
   assign slot  = (state_q == ST_PLAY) && (tick_q == TICK_LAST) && !flush;
   assign pop   = slot && !empty;

   // Write ack is combinational; read ack lands in the second strobe cycle.
   assign wb_ack = resetn && ((wr && !stall) || (rd && req_q && !ack_q));

   assign head_word = mem[rd_ptr_q];

   always_comb begin
      rd_data = 32'd0;
      case (wb_adr)
         ADR_STATUS: rd_data = {13'd0, state_q == ST_PLAY, empty, full, 16'(fill_q)};
         ADR_UNDER:  rd_data = {16'd0, under_cnt_q};
         default:    rd_data = 32'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      stage_d     = stage_q;
      under_cnt_d = under_cnt_q;
      req_d       = req;
      ack_d       = wb_ack;
      dat_d       = dat_q;
      pcm_valid_d = 1'b0;
      pcm_left_d  = pcm_left_q;
      pcm_right_d = pcm_right_q;
      underrun_d  = 1'b0;

      // Capture read data on the first cycle of each strobe
      if (rd && !(req_q && !ack_q))
         dat_d = rd_data;

      if (wr && (wb_adr == ADR_LEFT))
         stage_d = wb_dat_i[15:0];

      if (push)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)
         fill_d = fill_q + 1'b1;
      else if (pop && !push)
         fill_d = fill_q - 1'b1;

      case (state_q)
         ST_PREFILL: begin
            tick_d = '0;
            if (fill_q > FILL_START)
               state_d = ST_PLAY;
         end
         default: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (slot && empty)
                  state_d = ST_PREFILL;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
      endcase

      if (pop) begin
         pcm_valid_d = 1'b1;
         pcm_left_d  = head_word[31:16];
         pcm_right_d = head_word[15:0];
      end else if (slot) begin
         pcm_valid_d = 1'b1;
         pcm_left_d  = 16'd0;
         pcm_right_d = 16'd0;
         underrun_d  = 1'b1;
         if (under_cnt_q != 16'hFFFF)
            under_cnt_d = under_cnt_q + 1'b1;
      end

      if (wr && (wb_adr == ADR_UNDER))
         under_cnt_d = 16'd0;

      // Flush leaves the PCM outputs and underrun count alone
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
         stage_d  = 16'd0;
         tick_d   = '0;
         state_d  = ST_PREFILL;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_PREFILL;
         tick_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         stage_q     <= 16'd0;
         under_cnt_q <= 16'd0;
         req_q       <= 1'b0;
         ack_q       <= 1'b0;
         dat_q       <= 32'd0;
         pcm_valid_q <= 1'b0;
         pcm_left_q  <= 16'd0;
         pcm_right_q <= 16'd0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         stage_q     <= stage_d;
         under_cnt_q <= under_cnt_d;
         req_q       <= req_d;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
         pcm_valid_q <= pcm_valid_d;
         pcm_left_q  <= pcm_left_d;
         pcm_right_q <= pcm_right_d;
         underrun_q  <= underrun_d;
      end
   end

   // Sample storage carries no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_q] <= {stage_q, wb_dat_i[15:0]};
   end

   assign wb_dat_o  = dat_q;
   assign pcm_valid = pcm_valid_q;
   assign pcm_left  = pcm_left_q;
   assign pcm_right = pcm_right_q;
   assign underrun  = underrun_q;

endmodule
